// File: rtl/uart_rx_capture.sv
// uart_rx_capture: oversampling UART receiver (16 ticks per bit, centre sample
// at phase 7) with glitch rejection, parity/framing/overrun detection and a
// show-ahead receive FIFO.
module uart_rx_capture #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      baud_div,
  input  logic             rx_in,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [CNT_W-1:0] fifo_count,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun,
  input  logic             err_clr,
  output logic             busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Saturating occupancy update: never past FIFO_DEPTH, never below zero.
  function automatic logic [CNT_W-1:0] count_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
    if (inc && !dec && cnt != CNT_W'(FIFO_DEPTH)) return cnt + CNT_W'(1);
    if (dec && !inc && cnt != '0) return cnt - CNT_W'(1);
    return cnt;
  endfunction

  // Parity bit value the transmitter should have sent for this data word.
  function automatic logic expected_parity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [3:0]             phase_q, phase_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   stop_bad_q, stop_bad_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   frame_err_q, frame_err_d;
  logic                   parity_err_q, parity_err_d;
  logic                   overrun_q, overrun_d;
  logic                   tick, sample, push_req, frame_evt, parity_evt;
  logic                   pop, push, full, ovr_evt;

  // Two-flop synchroniser plus a delayed copy for start-edge detection.
  always_comb begin
    sync1_d = rx_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Tick generator, bit phase and frame FSM next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    stop_bad_d = stop_bad_q;
    push_req   = 1'b0;
    frame_evt  = 1'b0;
    parity_evt = 1'b0;
    tick       = (state_q != IDLE) && (cnt_q == '0);
    sample     = tick && (phase_q == 4'd7);

    // Holding the divider in IDLE aligns tick phase to the start edge.
    if (state_q == IDLE) begin
      cnt_d   = baud_div;
      phase_d = '0;
    end else if (tick) begin
      cnt_d   = baud_div;
      phase_d = phase_q + 4'd1;
    end else begin
      cnt_d   = cnt_q - 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d    = START;
          bit_cnt_d  = '0;
          stop_bad_d = 1'b0;
        end
      end
      START: begin
        // A start bit that is high again at its centre was a glitch.
        if (sample) state_d = sync2_q ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (sample) begin
          parity_evt = (sync2_q != expected_parity(shift_q));
          state_d    = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          frame_evt = !sync2_q;
          // Leave at the last stop centre so a following start edge is seen.
          if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
            state_d  = IDLE;
            push_req = !stop_bad_q && sync2_q;
          end else begin
            bit_cnt_d  = bit_cnt_q + 3'd1;
            stop_bad_d = stop_bad_q | !sync2_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer/occupancy and sticky error flag next-state logic.
  always_comb begin
    pop     = rd_en && (count_q != '0);
    full    = (count_q == CNT_W'(FIFO_DEPTH));
    push    = push_req && (!full || pop);
    ovr_evt = push_req && full && !pop;
    count_d = count_next(count_q, push, pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    // An error event in the same cycle as err_clr wins.
    frame_err_d  = (frame_err_q  & ~err_clr) | frame_evt;
    parity_err_d = (parity_err_q & ~err_clr) | parity_evt;
    overrun_d    = (overrun_q    & ~err_clr) | ovr_evt;
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      cnt_q        <= '0;
      phase_q      <= '0;
      bit_cnt_q    <= '0;
      stop_bad_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_bad_q   <= stop_bad_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // Data path: shift register and FIFO storage carry no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  // Show-ahead read port; reads zero while empty.
  always_comb begin
    rd_data = '0;
    if (count_q != '0) rd_data[DATA_BITS-1:0] = mem_q[rd_ptr_q];
  end

  assign rd_valid   = (count_q != '0);
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_capture.sv
// Testbench for uart_rx_capture: an 8N1 instance and an 8E1 instance,
// scoreboard queues of expected bytes, a vector table and corner sequences.
module tb_uart_rx_capture;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst;
  logic [15:0] baud_div0, baud_div1;
  logic        rx0, rx1, rd_en0, rd_en1, err_clr0, err_clr1;
  logic [7:0]  rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1;
  logic [4:0]  count0, count1;
  logic        ferr0, ferr1, perr0, perr1, ovr0, ovr1, busy0, busy1;

  uart_rx_capture u_dut (
    .clk(clk), .rst(rst), .baud_div(baud_div0), .rx_in(rx0), .rd_en(rd_en0),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .fifo_count(count0),
    .frame_err(ferr0), .parity_err(perr0), .overrun(ovr0),
    .err_clr(err_clr0), .busy(busy0));

  uart_rx_capture #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .clk(clk), .rst(rst), .baud_div(baud_div1), .rx_in(rx1), .rd_en(rd_en1),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .fifo_count(count1),
    .frame_err(ferr1), .parity_err(perr1), .overrun(ovr1),
    .err_clr(err_clr1), .busy(busy1));

  typedef struct {
    logic [7:0] data;
    logic       stop_lvl;
    logic       exp_ferr;
  } vec_t;

  vec_t       vecs [6];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc;
  logic [7:0] sb0 [$];
  logic [7:0] sb1 [$];
  logic [7:0] exp_b;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx0 = v; else rx1 = v;
  endtask

  // par < 0 means no parity bit; otherwise par[0] is sent as the parity bit.
  task automatic send_frame(input int sel, input logic [7:0] d, input int par,
                            input logic stop_lvl, input int bclk);
    set_rx(sel, 1'b0);
    wait_clks(bclk);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, d[i]);
      wait_clks(bclk);
    end
    if (par >= 0) begin
      set_rx(sel, par[0]);
      wait_clks(bclk);
    end
    set_rx(sel, stop_lvl);
    wait_clks(bclk);
    set_rx(sel, 1'b1);
  endtask

  task automatic pop_check(input int sel, input string name);
    if (sel == 0) begin
      chk({name, " valid"}, rd_valid0, 1);
      if (sb0.size() > 0) chk(name, rd_data0, sb0.pop_front());
      else chk({name, " scoreboard empty"}, 0, 1);
      rd_en0 = 1'b1;
      wait_clks(1);
      rd_en0 = 1'b0;
    end else begin
      chk({name, " valid"}, rd_valid1, 1);
      if (sb1.size() > 0) chk(name, rd_data1, sb1.pop_front());
      else chk({name, " scoreboard empty"}, 0, 1);
      rd_en1 = 1'b1;
      wait_clks(1);
      rd_en1 = 1'b0;
    end
  endtask

  task automatic pulse_clr0();
    err_clr0 = 1'b1;
    wait_clks(1);
    err_clr0 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'h00, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h81, 1'b0, 1'b1};
    vecs[3] = '{8'h3C, 1'b1, 1'b0};
    vecs[4] = '{8'hC3, 1'b0, 1'b1};
    vecs[5] = '{8'h5A, 1'b1, 1'b0};

    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rd_en0 = 1'b0; rd_en1 = 1'b0;
    err_clr0 = 1'b0; err_clr1 = 1'b0; baud_div0 = 16'd26; baud_div1 = 16'd26;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2);

    chk("reset rd_valid", rd_valid0, 0);
    chk("reset fifo_count", count0, 0);
    chk("reset rd_data", rd_data0, 0);
    chk("reset frame_err", ferr0, 0);
    chk("reset parity_err", perr0, 0);
    chk("reset overrun", ovr0, 0);
    chk("reset busy", busy0, 0);

    // 0x55 at 432 clk/bit: byte visible about 9.5 bit times after the edge.
    fork
      send_frame(0, 8'h55, -1, 1'b1, 432);
      begin
        cyc = 0;
        while (!rd_valid0 && cyc < 6000) begin
          wait_clks(1);
          cyc++;
        end
      end
    join
    chk("t1 latency window", (cyc >= 4050 && cyc <= 4200), 1);
    sb0.push_back(8'h55);
    chk("t1 fifo_count", count0, 1);
    pop_check(0, "t1 data");
    chk("t1 rd_valid after pop", rd_valid0, 0);
    chk("t1 count after pop", count0, 0);
    chk("t1 flags", {ferr0, perr0, ovr0}, 0);

    // Start glitch of 3 ticks.
    rx0 = 1'b0;
    wait_clks(81);
    chk("glitch busy during low", busy0, 1);
    rx0 = 1'b1;
    cyc = 0;
    while (busy0 && cyc < 400) begin
      wait_clks(1);
      cyc++;
    end
    chk("glitch busy returns before phase 7", (busy0 == 1'b0 && cyc < 200), 1);
    wait_clks(100);
    chk("glitch fifo_count", count0, 0);
    chk("glitch flags", {ferr0, perr0, ovr0}, 0);

    // Framing error.
    send_frame(0, 8'hA5, -1, 1'b0, 432);
    wait_clks(432);
    chk("ferr set", ferr0, 1);
    chk("ferr byte discarded", count0, 0);
    pulse_clr0();
    chk("ferr cleared", ferr0, 0);

    // Even parity: 0x07 needs parity bit 1.
    send_frame(1, 8'h07, 0, 1'b1, 432);
    wait_clks(10);
    chk("perr set", perr1, 1);
    chk("perr rd_data", rd_data1, 8'h07);
    chk("perr fifo_count", count1, 1);
    sb1.push_back(8'h07);
    err_clr1 = 1'b1;
    wait_clks(1);
    err_clr1 = 1'b0;
    chk("perr cleared", perr1, 0);
    send_frame(1, 8'h07, 1, 1'b1, 432);
    wait_clks(10);
    chk("good parity no perr", perr1, 0);
    chk("good parity count", count1, 2);
    chk("parity inst other flags", {ferr1, ovr1, busy1}, 0);
    sb1.push_back(8'h07);
    pop_check(1, "parity pop0");
    pop_check(1, "parity pop1");
    chk("parity inst empty", rd_valid1, 0);

    // Vector table at 64 clk/bit.
    baud_div0 = 16'd3;
    for (int v = 0; v < 6; v++) begin
      send_frame(0, vecs[v].data, -1, vecs[v].stop_lvl, 64);
      if (!vecs[v].stop_lvl) wait_clks(64);
      chk($sformatf("vec%0d frame_err", v), ferr0, vecs[v].exp_ferr);
      if (!vecs[v].exp_ferr) sb0.push_back(vecs[v].data);
      pulse_clr0();
    end
    chk("vec fifo_count", count0, sb0.size());
    while (sb0.size() > 0) pop_check(0, "vec data");
    chk("vec drained", rd_valid0, 0);

    // 17 back-to-back frames, no reads.
    for (int i = 0; i < 17; i++) begin
      send_frame(0, 8'(i), -1, 1'b1, 64);
      if (i < 16) sb0.push_back(8'(i));
    end
    wait_clks(10);
    chk("full fifo_count", count0, 16);
    chk("overrun set", ovr0, 1);
    pulse_clr0();
    chk("overrun cleared", ovr0, 0);

    // Pop in the exact cycle of the stop sample while full.
    fork
      send_frame(0, 8'h11, -1, 1'b1, 64);
      begin
        wait_clks(610);
        exp_b = sb0.pop_front();
        chk("simul pop data", rd_data0, exp_b);
        rd_en0 = 1'b1;
        wait_clks(1);
        rd_en0 = 1'b0;
      end
    join
    sb0.push_back(8'h11);
    chk("simul count unchanged", count0, 16);
    chk("simul no overrun", ovr0, 0);
    for (int i = 0; i < 16; i++) pop_check(0, $sformatf("drain%0d", i));
    chk("drain empty", rd_valid0, 0);

    // Put state in place so the reset has something to clear.
    send_frame(0, 8'h99, -1, 1'b0, 64);
    wait_clks(64);
    send_frame(0, 8'h42, -1, 1'b1, 64);
    wait_clks(10);
    chk("pre-reset count", count0, 1);
    chk("pre-reset ferr", ferr0, 1);

    // Reset in the middle of data bit 4 of 0x3C.
    baud_div0 = 16'd26;
    rx0 = 1'b0;
    wait_clks(432);
    for (int i = 0; i < 4; i++) begin
      rx0 = exp_b[0] | 1'b0;
      rx0 = (8'h3C >> i) & 8'h01;
      wait_clks(432);
    end
    rx0 = 1'b1;
    wait_clks(216);
    chk("mid-frame busy", busy0, 1);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    chk("rst busy", busy0, 0);
    chk("rst count", count0, 0);
    chk("rst rd_valid", rd_valid0, 0);
    chk("rst flags", {ferr0, perr0, ovr0}, 0);
    sb0.delete();
    wait_clks(864);
    send_frame(0, 8'h3C, -1, 1'b1, 432);
    wait_clks(10);
    chk("post-reset count", count0, 1);
    sb0.push_back(8'h3C);
    pop_check(0, "post-reset data");
    chk("post-reset flags", {ferr0, perr0, ovr0}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_capture.md
Name: uart_rx_capture

Overview:
- Parametrised, synthesisable UART receiver with a receive FIFO. It is the successor to the fixed 115200-baud bench-only RX monitor on uart_stx.
- Adds: runtime baud divider, configurable frame format, glitch rejection, error detection, and buffered readout.
- Sits on the SoC UART TX line, either in the bench or on-chip as a debug console capture.
- Runs on the 50 MHz system clock.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8); received bits land in rd_data[DATA_BITS-1:0], upper bits read 0.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even (used only when PARITY_EN=1).
- STOP_BITS, 1, number of stop bits checked (1 or 2).
- FIFO_DEPTH, 16, receive FIFO entries (power of 2, >= 2).
- CNT_W, 5, width of fifo_count; must satisfy 2^CNT_W > FIFO_DEPTH.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- baud_div  input  16  system clocks per oversample tick, minus 1 (16 ticks per bit)
- rx_in  input  1  serial line, idle high, asynchronous
- rd_en  input  1  pop request; ignored when rd_valid=0
- rd_data  output  8  head-of-FIFO byte (show-ahead)
- rd_valid  output  1  FIFO not empty
- fifo_count  output  CNT_W  entries held
- frame_err  output  1  sticky: a stop bit was sampled low
- parity_err  output  1  sticky: parity mismatch
- overrun  output  1  sticky: a byte was dropped because the FIFO was full
- err_clr  input  1  clears all sticky flags
- busy  output  1  a frame is in progress (state != IDLE)

Behaviour:
- Reset (synchronous, rst=1 at posedge clk), applies mid-frame too:
  - FSM goes to IDLE; FIFO emptied.
  - rd_valid=0, fifo_count=0, rd_data=0, all error flags=0, busy=0, synchroniser flops=1.
- Input path: rx_in passes through a 2-flop synchroniser; all line decisions use the second-flop output.
- Tick generator:
  - Counter loads baud_div and counts down; a tick pulses one cycle when it reaches 0.
  - A baud_div change takes effect at the next reload.
  - Counter is held at baud_div while in IDLE, so tick phase aligns to the detected start edge.
- Phase counter: 0..15, advances on each tick; the bit sample point is phase 7.
- FSM states IDLE, START, DATA, PARITY, STOP:
  - IDLE -> START on a synchronised 1->0 transition; phase cleared.
  - START samples at phase 7. Low: go to DATA, phase restarts. High: glitch, return to IDLE, nothing pushed.
  - DATA samples DATA_BITS bits LSB first, one per 16 ticks, each at phase 7.
  - After the last data bit: PARITY if PARITY_EN=1, else STOP.
  - PARITY samples one bit. Mismatch against the even/odd rule sets parity_err.
  - STOP samples STOP_BITS bits. Any low sample sets frame_err.
  - STOP -> IDLE at the last stop-bit sample point, so a start edge in the second half of the stop bit is caught (back-to-back frames).
- FIFO push happens on the cycle of the final stop-bit sample:
  - Framing error: byte discarded.
  - Parity error: byte still pushed.
  - FIFO full and no pop that cycle: byte dropped and overrun set.
  - FIFO full with a pop that same cycle: push succeeds; fifo_count is unchanged.
- FIFO read:
  - rd_data/rd_valid update the cycle after a push into an empty FIFO (latency 1 clk from the stop sample).
  - rd_en with rd_valid=1 pops; the next entry appears the following cycle.
  - fifo_count never wraps: it saturates at FIFO_DEPTH and never goes below 0.
- Sticky flags:
  - err_clr clears them.
  - If an error event and err_clr occur in the same cycle, the flag ends up set (event wins).
- busy=1 from the IDLE->START transition until the return to IDLE.

Test Plan:
- Format: baud_div=26 (27 clk/tick, 432 clk/bit, about 115.7 kbaud at 50 MHz), 8N1.
- Send 0x55 -> rd_valid=1 and rd_data=0x55 about 9.5 bit times after the start edge; fifo_count=1. Then pulse rd_en -> rd_valid=0, fifo_count=0, no error flags set.
- rx_in low for 3 ticks (81 clk) then high -> busy returns to 0 by phase 7 of the start bit; fifo_count stays 0; no flags set.
- Send 0xA5 with the stop bit driven low -> frame_err=1, fifo_count=0. Pulse err_clr -> frame_err=0.
- PARITY_EN=1, PARITY_ODD=0; send 0x07 with parity bit 0 -> parity_err=1, rd_data=0x07, fifo_count=1. Send 0x07 with parity bit 1 -> parity_err unchanged and not newly set after a clear.
- 17 back-to-back frames 0x00..0x10, no reads -> fifo_count=16, overrun=1; reading 16 times returns 0x00..0x0F in order, then rd_valid=0.
- Assert rst for 1 cycle during data bit 4 of 0x3C -> next cycle busy=0, fifo_count=0, all flags 0. The following clean 0x3C frame is received correctly.
